// File: rtl/rdid_lcd_display.sv
// rdid_lcd_display: shows the three JEDEC RDID bytes as "ID: MM TT CC" on
// line 1 of an HD44780 16x2 LCD driven over a write-only 4-bit bus.
// Runs the LCD power-up init once after reset, then rewrites the line on
// every id_valid. An id_valid that arrives while busy is held in a 1-deep
// pending slot (newest wins) and serviced when the block next goes idle.
// Ports:
//   clk, reset (async, active-low)
//   id_valid, manufacture_id[7:0], memory_type[7:0], memory_capacity[7:0]
//   LCD_D[3:0], LCD_E, LCD_RS, LCD_RW (always 0), busy
module rdid_lcd_display #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned E_PULSE        = 12,
    parameter int unsigned NIBBLE_GAP     = 50,
    parameter int unsigned CMD_WAIT       = 2000,
    parameter int unsigned CLEAR_WAIT     = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [7:0] manufacture_id,
    input  logic [7:0] memory_type,
    input  logic [7:0] memory_capacity,
    output logic [3:0] LCD_D,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       busy
);

    localparam int unsigned CNT_MAX = POWERUP_CYCLES + CLEAR_WAIT + CMD_WAIT
                                    + NIBBLE_GAP + E_PULSE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_LINE} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_E, PH_WAIT} phase_t;

    state_t             r_state;
    phase_t             r_ph;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_idx;
    logic               r_lower;
    logic [7:0]         r_m, r_t, r_c;
    logic               r_pend;
    logic [7:0]         r_pm, r_pt, r_pc;

    logic [7:0]         w_cur_byte;
    logic [7:0]         w_nxt_byte;
    logic [3:0]         w_nxt_idx;
    logic [3:0]         w_nxt_nib;
    logic               w_single;
    logic               w_last;
    logic [CNT_W-1:0]   w_wait;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Byte for step idx: init sequence (first four are single nibbles in [3:0]) or line text
    function automatic logic [7:0] item_byte(input logic is_init, input logic [3:0] idx,
                                             input logic [7:0] m, input logic [7:0] t,
                                             input logic [7:0] c);
        logic [7:0] b;
        b = 8'h20;
        if (is_init) begin
            case (idx)
                4'd0, 4'd1, 4'd2: b = 8'h03;
                4'd3:             b = 8'h02;
                4'd4:             b = 8'h28;
                4'd5:             b = 8'h06;
                4'd6:             b = 8'h0C;
                default:          b = 8'h01;
            endcase
        end else begin
            case (idx)
                4'd0:    b = 8'h80;
                4'd1:    b = 8'h49;
                4'd2:    b = 8'h44;
                4'd3:    b = 8'h3A;
                4'd5:    b = hex_ascii(m[7:4]);
                4'd6:    b = hex_ascii(m[3:0]);
                4'd8:    b = hex_ascii(t[7:4]);
                4'd9:    b = hex_ascii(t[3:0]);
                4'd11:   b = hex_ascii(c[7:4]);
                4'd12:   b = hex_ascii(c[3:0]);
                default: b = 8'h20;
            endcase
        end
        return b;
    endfunction

    // Current/next step decode and the wait that follows the current nibble
    always_comb begin
        w_cur_byte = item_byte(r_state == ST_INIT, r_idx, r_m, r_t, r_c);
        w_nxt_idx  = r_idx + 4'd1;
        w_nxt_byte = item_byte(r_state == ST_INIT, w_nxt_idx, r_m, r_t, r_c);
        w_single   = (r_state == ST_INIT) && (r_idx < 4'd4);
        w_last     = (r_state == ST_INIT) ? (r_idx == 4'd7) : (r_idx == 4'd12);
        w_nxt_nib  = ((r_state == ST_INIT) && (w_nxt_idx < 4'd4)) ? w_nxt_byte[3:0]
                                                                    : w_nxt_byte[7:4];
        w_wait     = CNT_W'(NIBBLE_GAP - 1);
        if (w_single || r_lower) begin
            w_wait = ((r_state == ST_INIT) && (r_idx == 4'd7)) ? CNT_W'(CLEAR_WAIT - 1)
                                                                 : CNT_W'(CMD_WAIT - 1);
        end
    end

    assign LCD_RW = 1'b0;

    // Sequencer: top-level state plus per-nibble setup / E-high / wait phases
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_PWRUP;
            r_ph    <= PH_SETUP;
            r_cnt   <= CNT_W'(POWERUP_CYCLES - 1);
            r_idx   <= 4'd0;
            r_lower <= 1'b0;
            r_m     <= 8'h00;
            r_t     <= 8'h00;
            r_c     <= 8'h00;
            r_pend  <= 1'b0;
            r_pm    <= 8'h00;
            r_pt    <= 8'h00;
            r_pc    <= 8'h00;
            LCD_D   <= 4'h0;
            LCD_E   <= 1'b0;
            LCD_RS  <= 1'b0;
            busy    <= 1'b1;
        end else begin
            // Any request outside IDLE parks in the pending slot; later ones overwrite
            if (id_valid && (r_state != ST_IDLE)) begin
                r_pend <= 1'b1;
                r_pm   <= manufacture_id;
                r_pt   <= memory_type;
                r_pc   <= memory_capacity;
            end
            case (r_state)
                ST_PWRUP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_INIT;
                        r_idx   <= 4'd0;
                        r_lower <= 1'b0;
                        r_ph    <= PH_SETUP;
                        LCD_D   <= 4'h3;
                        LCD_RS  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (id_valid || r_pend) begin
                        // A fresh id_valid is newer than anything pending
                        r_m     <= id_valid ? manufacture_id  : r_pm;
                        r_t     <= id_valid ? memory_type     : r_pt;
                        r_c     <= id_valid ? memory_capacity : r_pc;
                        r_pend  <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_LINE;
                        r_idx   <= 4'd0;
                        r_lower <= 1'b0;
                        r_ph    <= PH_SETUP;
                        LCD_D   <= 4'h8;
                        LCD_RS  <= 1'b0;
                    end
                end
                default: begin
                    case (r_ph)
                        PH_SETUP: begin
                            LCD_E <= 1'b1;
                            r_ph  <= PH_E;
                            r_cnt <= CNT_W'(E_PULSE - 1);
                        end
                        PH_E: begin
                            if (r_cnt == '0) begin
                                LCD_E <= 1'b0;
                                r_ph  <= PH_WAIT;
                                r_cnt <= w_wait;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                        default: begin
                            if (r_cnt != '0) begin
                                r_cnt <= r_cnt - 1'b1;
                            end else if (!w_single && !r_lower) begin
                                r_lower <= 1'b1;
                                r_ph    <= PH_SETUP;
                                LCD_D   <= w_cur_byte[3:0];
                            end else if (w_last) begin
                                r_state <= ST_IDLE;
                                r_lower <= 1'b0;
                                busy    <= 1'b0;
                            end else begin
                                r_idx   <= w_nxt_idx;
                                r_lower <= 1'b0;
                                r_ph    <= PH_SETUP;
                                LCD_D   <= w_nxt_nib;
                                LCD_RS  <= (r_state == ST_LINE);
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule
